btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
Parametrised multi-channel successor to the single-button synchroniser plus shift-register debouncer.
- Each channel takes an asynchronous pad input and passes it through an N-stage synchroniser.
- A saturating counter filters both press and release symmetrically, replacing the rise-only AND-of-flops filter.
- Outputs per channel: a clean level, single-cycle press/release strobes, and an optional long-press strobe.
- Sits between board pins (buttons/switches) and user logic or LED drivers in the clk_100mhz domain.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 3, synchroniser depth per channel (>=2)
DEBOUNCE_CYCLES, 100, consecutive stable samples required to change output level (>=1)
HOLD_CYCLES, 0, cycles dout must stay high before hold strobe fires; 0 disables hold logic
ACTIVE_LOW, 0, 1 inverts din after synchronisation (for pull-up buttons)

Ports:
clk  input  1  single clock; all logic on rising edge
rstn  input  1  asynchronous active-low reset
din  input  CHANNELS  raw asynchronous pad inputs, one bit per channel
dout  output  CHANNELS  debounced level per channel
rise  output  CHANNELS  one-cycle strobe, dout 0->1
fall  output  CHANNELS  one-cycle strobe, dout 1->0
hold  output  CHANNELS  one-cycle strobe after dout high HOLD_CYCLES cycles (tied 0 if HOLD_CYCLES=0)

Behaviour:
- Reset: all synchroniser flops, counters, dout, rise, fall, hold = 0, applied asynchronously.
- Reset release is synchronous to clk (upstream reset subsystem guarantees this).
- Synchroniser: SYNC_STAGES flops in series per channel. s = last stage, XOR ACTIVE_LOW. No logic between stages.
- Debounce counter: cnt per channel, width clog2(DEBOUNCE_CYCLES+1). Each cycle:
  - s == dout: cnt <= 0.
  - s != dout and cnt == DEBOUNCE_CYCLES-1: dout <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Result: dout toggles only after exactly DEBOUNCE_CYCLES consecutive samples of s differing from dout. Any agreeing sample restarts the count (glitch rejection).
- Latency: after a clean din edge, the change on dout appears SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new din. Press and release latency are identical.
- rise/fall: registered and asserted in the same cycle dout first shows the new value, for exactly 1 cycle. rise and fall are never both high in a channel.
- Hold (HOLD_CYCLES>0): hcnt per channel, width clog2(HOLD_CYCLES+1).
  - Cleared while dout==0.
  - Increments while dout==1, saturating at HOLD_CYCLES.
  - hold pulses 1 cycle when hcnt transitions to HOLD_CYCLES, i.e. the cycle HOLD_CYCLES after rise.
  - Fires at most once per press; re-arms only after fall.
  - If fall occurs the same cycle hcnt would reach HOLD_CYCLES, hold is suppressed.
- Channels fully independent; simultaneous events on different channels all reported in the same cycle.
- DEBOUNCE_CYCLES=1: dout follows s with one register of delay, and each change still produces rise/fall.
- Reset mid-count: all state cleared immediately. After release, a held-high din re-qualifies from zero and produces a fresh rise.
- No combinational path from din to any output.

Test Plan:
(All with CHANNELS=4, SYNC_STAGES=3, DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, ACTIVE_LOW=0, unless noted.)
1. Reset: hold rstn=0 with din=4'hF, then release → dout=rise=fall=hold=0 during reset. din[0] stable 1 → dout[0]=1 and rise[0]=1 exactly 11 edges after first post-reset edge; rise[0] low next cycle.
2. Bounce: din[1] toggles 1/0 every 3 cycles for 40 cycles, then settles 1 → dout[1] stays 0 throughout bounce. dout[1] rises exactly 11 edges after the final settle; exactly one rise[1] pulse, no fall[1].
3. Release: from dout[2]=1, drive din[2]=0 with a 7-cycle-wide 1 glitch after 5 low cycles → glitch restarts count. fall[2] fires 8 cycles after glitch clears through sync, once only.
4. Hold: din[3] high for 40 cycles → rise[3] at T, hold[3] one-cycle at T+20, no second hold. Release and re-press 30 cycles → second hold at new T'+20. Press of 15 cycles → no hold.
5. Multi-channel and ACTIVE_LOW=1: din=4'hF→4'h0 simultaneously → all four rise bits high in the same cycle. din=4'hF stable → dout=0.
6. Reset mid-count: din[0]=1, assert rstn=0 at cycle 5 of the debounce count for 2 cycles → outputs 0 immediately. rise[0] arrives 11 edges after reset release, not earlier.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// Multi-channel button/switch conditioner.
// Each channel: N-flop synchroniser, optional polarity inversion, symmetric
// saturating-count debounce, registered rise/fall strobes and an optional
// long-press (hold) strobe. Channels are fully independent.
module btn_debounce_multi #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int HOLD_CYCLES     = 0,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             INV      = (ACTIVE_LOW != 0);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt;
        logic                   dout_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   s;
        logic                   flip;
        logic                   falling;

        // Polarity is applied after the last sync flop so the chain stays plain flops.
        assign s       = sync_q[SYNC_STAGES-1] ^ INV;
        // Level changes on the sample that completes the run of disagreeing samples.
        assign flip    = (s != dout_q) && (cnt == CNT_LAST);
        assign falling = flip && !s;

        // Synchroniser chain: no logic between stages.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], din[ch]};
            end
        end

        // Debounce counter and registered level/edge strobes.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt    <= '0;
                dout_q <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= flip && s;
                fall_q <= falling;
                if (s == dout_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    dout_q <= s;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end

        assign dout[ch] = dout_q;
        assign rise[ch] = rise_q;
        assign fall[ch] = fall_q;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int            H_W   = $clog2(HOLD_CYCLES + 1);
            localparam logic [H_W-1:0] H_MAX = H_W'(HOLD_CYCLES);
            localparam logic [H_W-1:0] H_PRE = H_W'(HOLD_CYCLES - 1);
            localparam logic [H_W-1:0] H_ONE = H_W'(1);

            logic [H_W-1:0] hcnt;
            logic           hold_q;

            // Long-press timer; saturation makes the strobe fire once per press,
            // and a release landing on the terminal cycle suppresses it.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    hcnt   <= '0;
                    hold_q <= 1'b0;
                end else if (!dout_q) begin
                    hcnt   <= '0;
                    hold_q <= 1'b0;
                end else begin
                    hold_q <= (hcnt == H_PRE) && !falling;
                    if (hcnt != H_MAX) begin
                        hcnt <= hcnt + H_ONE;
                    end
                end
            end

            assign hold[ch] = hold_q;
        end else begin : g_no_hold
            assign hold[ch] = 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: CHANNELS=4, SYNC_STAGES=3,
// DEBOUNCE_CYCLES=8, HOLD_CYCLES=20. A second instance uses ACTIVE_LOW=1.
// Edge counts are relative to the first edge that samples a new din value;
// a level change shows 3+8=11 edges later, hold 20 edges after rise.
module tb_btn_debounce_multi;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] din;
    logic [3:0] dout, rise, fall, hold;
    logic [3:0] din_al;
    logic [3:0] dout_al, rise_al, fall_al, hold_al;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cnt_a, cnt_b;

    btn_debounce_multi #(
        .CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES(20), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rstn(rstn), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .hold(hold)
    );

    btn_debounce_multi #(
        .CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES(20), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rstn(rstn), .din(din_al),
        .dout(dout_al), .rise(rise_al), .fall(fall_al), .hold(hold_al)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Press channel 3 for n cycles; expect fall n+11 edges in and the given hold count.
    task automatic press3(input int n, input int exp_holds);
        int holds;
        holds = 0;
        din = 4'h8;
        for (int e = 1; e <= n + 15; e++) begin
            tick();
            if (e == n) din = 4'h0;
            if (hold[3]) holds++;
            if (e == 11) chk("press_rise", {28'd0, rise}, 32'h8);
            if (e == n + 11) chk("press_fall", {28'd0, fall}, 32'h8);
        end
        chk("press_hold_count", holds, exp_holds);
    endtask

    initial begin
        rstn   = 1'b0;
        din    = 4'hF;
        din_al = 4'hF;

        // Reset state with din high
        repeat (3) tick();
        chk("reset_outputs", {16'd0, dout, rise, fall, hold}, 32'h0);
        rstn = 1'b1;

        // First qualification after reset: all channels at edge 11
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("t1_dout_early", {28'd0, dout}, 32'h0);
        end
        tick();
        chk("t1_dout", {28'd0, dout}, 32'hF);
        chk("t1_rise", {28'd0, rise}, 32'hF);
        tick();
        chk("t1_rise_once", {28'd0, rise}, 32'h0);

        // Hold: rise visible after edge 11, hold after edge 31
        cnt_a = 0;
        for (int e = 13; e <= 30; e++) begin
            tick();
            if (hold != 4'h0) cnt_a++;
        end
        chk("hold_early", cnt_a, 0);
        tick();
        chk("hold_pulse", {28'd0, hold}, 32'hF);
        tick();
        chk("hold_one_cycle", {28'd0, hold}, 32'h0);
        cnt_a = 0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (hold != 4'h0) cnt_a++;
        end
        chk("hold_no_second", cnt_a, 0);
        chk("hold_dout_still_high", {28'd0, dout}, 32'hF);

        // Release all; fall at edge 11
        din = 4'h0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("rel_dout_early", {28'd0, dout}, 32'hF);
        end
        tick();
        chk("rel_fall", {28'd0, fall}, 32'hF);
        chk("rel_dout", {28'd0, dout}, 32'h0);
        tick();

        // Re-press: 30, 15, 20 (suppressed boundary), 21 cycles
        press3(30, 1);
        press3(15, 0);
        press3(20, 0);
        press3(21, 1);

        // Bounce on channel 1: no qualification while toggling every 3 cycles
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            din[1] = ((i / 3) % 2 == 0);
            tick();
            if (dout[1]) cnt_a++;
        end
        chk("bounce_dout_low", cnt_a, 0);
        cnt_a = 0;
        din[1] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (rise[1]) cnt_a++;
            chk("bounce_settle_early", {31'd0, dout[1]}, 32'h0);
        end
        for (int e = 11; e <= 31; e++) begin
            tick();
            if (rise[1]) cnt_a++;
            if (fall[1]) cnt_b++;
            if (e == 11) chk("bounce_rise", {31'd0, rise[1]}, 32'h1);
        end
        chk("bounce_rise_count", cnt_a, 1);
        chk("bounce_fall_count", cnt_b, 0);

        // Release with glitch on channel 2
        din[2] = 1'b1;
        repeat (15) tick();
        chk("glitch_pre_dout", {31'd0, dout[2]}, 32'h1);
        din[2] = 1'b0;
        repeat (5) tick();
        din[2] = 1'b1;
        repeat (7) tick();
        chk("glitch_dout_held", {31'd0, dout[2]}, 32'h1);
        din[2] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("glitch_early", {30'd0, dout[2], fall[2]}, 32'h2);
        end
        tick();
        chk("glitch_fall", {30'd0, dout[2], fall[2]}, 32'h1);
        cnt_a = 0;
        repeat (15) begin
            tick();
            if (fall[2]) cnt_a++;
        end
        chk("glitch_fall_once", cnt_a, 0);

        // Active-low instance: din high is released, din low is pressed
        din = 4'h0;
        din_al = 4'hF;
        do_reset();
        repeat (20) tick();
        chk("al_idle_dout", {28'd0, dout_al}, 32'h0);
        din_al = 4'h0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("al_early", {28'd0, dout_al}, 32'h0);
        end
        tick();
        chk("al_rise_all", {24'd0, dout_al, rise_al}, 32'hFF);
        tick();
        chk("al_rise_once", {24'd0, rise_al, fall_al}, 32'h0);
        chk("al_hold_idle", {28'd0, hold_al}, 32'h0);

        // Reset mid-count: channels 3..1 qualified, channel 0 at count 5
        din = 4'hE;
        repeat (15) tick();
        chk("mid_pre_dout", {28'd0, dout}, 32'hE);
        din = 4'hF;
        repeat (8) tick();
        chk("mid_not_yet", {28'd0, dout}, 32'hE);
        rstn = 1'b0;
        #1;
        chk("mid_async_clear", {28'd0, dout}, 32'h0);
        tick();
        tick();
        chk("mid_in_reset", {16'd0, dout, rise, fall, hold}, 32'h0);
        rstn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("mid_early", {28'd0, dout}, 32'h0);
        end
        tick();
        chk("mid_rise", {28'd0, rise}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
